lc3_regfile_cc: RTL



---
 rtl/lc3_pkg.sv | 24 ++
 rtl/lc3_cc_logic.sv | 27 ++
 rtl/lc3_regfile_cc.sv | 106 ++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// -----------------------------------------------------------------------------
// lc3_pkg
// Shared constants for the LC-3 datapath blocks.
//   LC3_WIDTH  : datapath / bus width in bits
//   LC3_NREG   : number of general-purpose registers
//   LC3_SEL_W  : width of a register select field
//   nzp_e      : one-hot condition-code encodings {N,Z,P}
//   NZP_RESET  : condition code after reset (Z, matching the zeroed registers)
// -----------------------------------------------------------------------------
package lc3_pkg;

  localparam int LC3_WIDTH = 16;
  localparam int LC3_NREG  = 8;
  localparam int LC3_SEL_W = $clog2(LC3_NREG);

  typedef enum logic [2:0] {
    NZP_N = 3'b100,
    NZP_Z = 3'b010,
    NZP_P = 3'b001
  } nzp_e;

  localparam logic [2:0] NZP_RESET = NZP_Z;

endpackage : lc3_pkg

// File: rtl/lc3_cc_logic.sv
// -----------------------------------------------------------------------------
// lc3_cc_logic
// Combinational encoder from a data word to the one-hot LC-3 condition code.
// The word is treated as two's-complement signed.
//   value : input  [W-1:0]  word to classify
//   nzp   : output [2:0]    {N,Z,P}, exactly one bit set
// -----------------------------------------------------------------------------
module lc3_cc_logic
  import lc3_pkg::*;
#(
  parameter int W = LC3_WIDTH
) (
  input  logic [W-1:0] value,
  output logic [2:0]   nzp
);

  // Sign bit takes priority; only a non-negative word can be zero or positive.
  always_comb begin
    nzp = NZP_P;
    if (value[W-1]) begin
      nzp = NZP_N;
    end else if (value == '0) begin
      nzp = NZP_Z;
    end
  end

endmodule : lc3_cc_logic

// File: rtl/lc3_regfile_cc.sv
// -----------------------------------------------------------------------------
// lc3_regfile_cc
// LC-3 general-purpose register file plus condition codes and branch enable.
// Captures the shared bus into R[dr], updates N/Z/P from the bus, registers BEN,
// and supplies two combinational read operands to the ALU.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : shared datapath bus
//   ld_reg   : write bus into R[dr] at the next edge
//   dr       : destination register select
//   sr1/sr2  : read port selects
//   sr1_out  : R[sr1], combinational
//   sr2_out  : R[sr2], combinational
//   ld_cc    : update N/Z/P from bus at the next edge
//   nzp      : registered condition codes {N,Z,P}
//   ir_nzp   : IR[11:9] branch condition field
//   ld_ben   : register BEN at the next edge
//   ben      : registered branch enable
// -----------------------------------------------------------------------------
module lc3_regfile_cc
  import lc3_pkg::*;
#(
  parameter int WIDTH = LC3_WIDTH,
  parameter int NREG  = LC3_NREG,
  parameter int SEL_W = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bus,
  input  logic             ld_reg,
  input  logic [SEL_W-1:0] dr,
  input  logic [SEL_W-1:0] sr1,
  input  logic [SEL_W-1:0] sr2,
  output logic [WIDTH-1:0] sr1_out,
  output logic [WIDTH-1:0] sr2_out,
  input  logic             ld_cc,
  output logic [2:0]       nzp,
  input  logic [2:0]       ir_nzp,
  input  logic             ld_ben,
  output logic             ben
);

  logic [WIDTH-1:0] regs_reg [NREG];
  logic [NREG-1:0]  wr_en;
  logic [2:0]       nzp_reg;
  logic [2:0]       nzp_next;
  logic             ben_reg;
  logic             ben_next;

  // One-hot write decode of the destination select.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_wr_dec
      assign wr_en[gi] = ld_reg && (dr == SEL_W'(gi));
    end
  endgenerate

  // Register array. Needs an asynchronous clear, so it is built from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_en[i]) begin
          regs_reg[i] <= bus;
        end
      end
    end
  end

  // Reads come straight from stored state: a same-cycle write is not
  // forwarded, so the old value shows until after the edge.
  assign sr1_out = regs_reg[sr1];
  assign sr2_out = regs_reg[sr2];

  // Condition codes from the same bus sample the register write uses.
  lc3_cc_logic #(
    .W (WIDTH)
  ) u_cc (
    .value (bus),
    .nzp   (nzp_next)
  );

  // BEN looks at the condition codes as they were before this edge, so a
  // concurrent ld_cc does not affect the branch decision.
  assign ben_next = |(ir_nzp & nzp_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nzp_reg <= NZP_RESET;
      ben_reg <= 1'b0;
    end else begin
      if (ld_cc) begin
        nzp_reg <= nzp_next;
      end
      if (ld_ben) begin
        ben_reg <= ben_next;
      end
    end
  end

  assign nzp = nzp_reg;
  assign ben = ben_reg;

endmodule : lc3_regfile_cc
